// File: rtl/yrv_arb_pkg.sv
// Shared types for the yrv memory-port arbiter: FSM states, data-phase owner
// and the idle transfer encoding.
package yrv_arb_pkg;

  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_AUX    = 2'd1,
    ST_REPLAY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_t;

  localparam logic [1:0] TRANS_IDLE = 2'b00;

endpackage

// File: rtl/yrv_arb_hold.sv
// One-entry address-phase hold register. Keeps a preempted CPU address phase
// so it can be replayed once the auxiliary master releases the bus.
module yrv_arb_hold #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          clear,
  input  logic [1:0]    d_trans,
  input  logic [AW-1:0] d_addr,
  input  logic          d_write,
  input  logic [3:0]    d_ble,
  output logic          valid,
  output logic [1:0]    q_trans,
  output logic [AW-1:0] q_addr,
  output logic          q_write,
  output logic [3:0]    q_ble
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      q_trans <= '0;
      q_addr  <= '0;
      q_write <= 1'b0;
      q_ble   <= '0;
    end else if (capture) begin
      valid   <= 1'b1;
      q_trans <= d_trans;
      q_addr  <= d_addr;
      q_write <= d_write;
      q_ble   <= d_ble;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/yrv_mem_arbiter.sv
// Shares the yrv_mcu memory port between the CPU and an auxiliary master.
// The CPU is preempted at a transfer boundary and its held transfer replayed.
module yrv_mem_arbiter
  import yrv_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_trans,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_write,
  input  logic [3:0]    cpu_ble,
  input  logic          cpu_lock,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  output logic          aux_gnt,
  input  logic [1:0]    aux_trans,
  input  logic [AW-1:0] aux_addr,
  input  logic          aux_write,
  input  logic [3:0]    aux_ble,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ready,
  output logic [DW-1:0] aux_rdata,
  output logic [1:0]    mem_trans,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [3:0]    mem_ble,
  output logic          mem_lock,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  arb_state_t    state_q, state_d;
  owner_t        owner_q;
  logic          sw;
  logic          hold_capture, hold_clear, hold_valid;
  logic [1:0]    hold_trans;
  logic [AW-1:0] hold_addr;
  logic          hold_write;
  logic [3:0]    hold_ble;

  yrv_arb_hold #(.AW(AW)) u_hold (
    .clk     (clk),
    .rst     (reset),
    .capture (hold_capture),
    .clear   (hold_clear),
    .d_trans (cpu_trans),
    .d_addr  (cpu_addr),
    .d_write (cpu_write),
    .d_ble   (cpu_ble),
    .valid   (hold_valid),
    .q_trans (hold_trans),
    .q_addr  (hold_addr),
    .q_write (hold_write),
    .q_ble   (hold_ble)
  );

  // A locked read-modify-write sequence is never split.
  assign sw = aux_req & ~cpu_lock;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CPU;
      owner_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
      if (mem_ready)
        owner_q <= (state_q == ST_AUX) ? OWN_AUX : OWN_CPU;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_capture = 1'b0;
    hold_clear   = 1'b0;
    mem_trans    = cpu_trans;
    mem_addr     = cpu_addr;
    mem_write    = cpu_write;
    mem_ble      = cpu_ble;
    mem_lock     = cpu_lock;
    cpu_ready    = mem_ready;
    aux_ready    = 1'b0;
    aux_gnt      = 1'b0;
    case (state_q)
      ST_CPU: begin
        if (sw) begin
          // The CPU sees its address accepted; the hold buffer owns it now.
          mem_trans = TRANS_IDLE;
          if (mem_ready) begin
            hold_capture = (cpu_trans != TRANS_IDLE);
            state_d      = ST_AUX;
          end
        end
      end
      ST_AUX: begin
        mem_trans = aux_trans;
        mem_addr  = aux_addr;
        mem_write = aux_write;
        mem_ble   = aux_ble;
        mem_lock  = 1'b0;
        aux_gnt   = 1'b1;
        aux_ready = mem_ready;
        cpu_ready = 1'b0;
        if (!aux_req && aux_trans == TRANS_IDLE && mem_ready)
          state_d = hold_valid ? ST_REPLAY : ST_CPU;
      end
      ST_REPLAY: begin
        mem_trans = hold_trans;
        mem_addr  = hold_addr;
        mem_write = hold_write;
        mem_ble   = hold_ble;
        mem_lock  = 1'b0;
        cpu_ready = 1'b0;
        if (mem_ready) begin
          hold_clear = 1'b1;
          state_d    = ST_CPU;
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

  assign mem_wdata = (owner_q == OWN_AUX) ? aux_wdata : cpu_wdata;
  assign cpu_rdata = mem_rdata;
  assign aux_rdata = mem_rdata;
  assign arb_state = state_q;

endmodule

// File: tb/tb_yrv_mem_arbiter.sv
// Self-checking bench for yrv_mem_arbiter: a word memory model plus a queue of
// expected address phases, each checked on acceptance and on its data phase.
module tb_yrv_mem_arbiter;

  logic        clk, rst;
  logic [1:0]  cpu_trans, aux_trans, mem_trans, arb_state;
  logic [31:0] cpu_addr, aux_addr, mem_addr;
  logic        cpu_write, aux_write, mem_write, cpu_lock, mem_lock;
  logic [3:0]  cpu_ble, aux_ble, mem_ble;
  logic [31:0] cpu_wdata, aux_wdata, mem_wdata, cpu_rdata, aux_rdata, mem_rdata;
  logic        cpu_ready, aux_ready, mem_ready, aux_req, aux_gnt;

  yrv_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(rst),
    .cpu_trans(cpu_trans), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_ble(cpu_ble), .cpu_lock(cpu_lock), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_gnt(aux_gnt),
    .aux_trans(aux_trans), .aux_addr(aux_addr), .aux_write(aux_write),
    .aux_ble(aux_ble), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .mem_trans(mem_trans), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_ble(mem_ble), .mem_lock(mem_lock), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .arb_state(arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_val(input int idx);
    return 32'hC0DE0000 | 32'(idx);
  endfunction

  // memory model: one outstanding data phase, reads return the word array
  logic [31:0] mem [0:1023];
  logic        mdp_valid, mdp_write;
  logic [9:0]  mdp_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdp_valid <= 1'b0;
      mdp_write <= 1'b0;
      mdp_idx   <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (mem_ready) begin
      if (mdp_valid && mdp_write) mem[mdp_idx] <= mem_wdata;
      mdp_valid <= (mem_trans != 2'b00);
      mdp_write <= mem_write;
      mdp_idx   <= mem_addr[11:2];
    end
  end

  assign mem_rdata = (mdp_valid && !mdp_write) ? mem[mdp_idx] : 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic        who;   // 0 = CPU consumes the data phase, 1 = AUX
  } exp_t;

  exp_t sb_q[$];
  exp_t dp_e;
  logic dp_pend = 1'b0;

  task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d, input logic who);
    exp_t e;
    e.addr = a; e.write = w; e.data = d; e.who = who;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_pend && mem_ready) begin
        if (dp_e.write) check_eq("dp_wdata", mem_wdata, dp_e.data);
        else            check_eq("dp_rdata", dp_e.who ? aux_rdata : cpu_rdata, dp_e.data);
        check_eq("dp_ready", {31'b0, dp_e.who ? aux_ready : cpu_ready}, 32'd1);
        check_eq("dp_other_ready", {31'b0, dp_e.who ? cpu_ready : aux_ready}, 32'd0);
        dp_pend = 1'b0;
      end
      if (mem_ready && mem_trans != 2'b00) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got accept at 0x%08h expected no transfer", mem_addr);
        end else begin
          dp_e = sb_q.pop_front();
          check_eq("ap_addr", mem_addr, dp_e.addr);
          check_eq("ap_write", {31'b0, mem_write}, {31'b0, dp_e.write});
          dp_pend = 1'b1;
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    cpu_trans = 2'b10; cpu_addr = '0; cpu_write = 1'b0; cpu_ble = 4'hF;
    cpu_lock = 1'b0; cpu_wdata = '0;
    aux_req = 1'b0; aux_trans = '0; aux_addr = '0; aux_write = 1'b0;
    aux_ble = 4'hF; aux_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", {30'b0, arb_state}, 32'd0);
    check_eq("rst_gnt", {31'b0, aux_gnt}, 32'd0);
    check_eq("rst_aux_ready", {31'b0, aux_ready}, 32'd0);
    check_eq("rst_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    check_eq("rst_mem_trans", {30'b0, mem_trans}, 32'd2);
    check_eq("rst_hold_valid", {31'b0, dut.hold_valid}, 32'd0);
    next_cyc();
    rst = 1'b0; cpu_trans = 2'b00;

    // CPU-only back-to-back reads
    for (int i = 0; i < 8; i++) begin
      cpu_trans = 2'b10; cpu_addr = 32'(i * 4); cpu_write = 1'b0;
      push_exp(32'(i * 4), 1'b0, init_val(i), 1'b0);
      @(negedge clk);
      check_eq("cpu_mem_addr", mem_addr, 32'(i * 4));
      check_eq("cpu_mem_trans", {30'b0, mem_trans}, 32'd2);
      check_eq("cpu_gnt", {31'b0, aux_gnt}, 32'd0);
      next_cyc();
    end
    cpu_trans = 2'b00;
    next_cyc();

    // preempt a CPU write to 0x100
    cpu_trans = 2'b10; cpu_addr = 32'h100; cpu_write = 1'b1; aux_req = 1'b1;
    @(negedge clk);
    check_eq("sw_mem_trans", {30'b0, mem_trans}, 32'd0);
    check_eq("sw_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    next_cyc();
    cpu_wdata = 32'h12345678; cpu_trans = 2'b10; cpu_addr = 32'h24; cpu_write = 1'b0;
    aux_trans = 2'b10; aux_addr = 32'h200; aux_write = 1'b1;
    push_exp(32'h200, 1'b1, 32'hA5A5A5A5, 1'b1);
    @(negedge clk);
    check_eq("aux_gnt", {31'b0, aux_gnt}, 32'd1);
    check_eq("aux_state", {30'b0, arb_state}, 32'd1);
    check_eq("aux_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check_eq("aux_mem_lock", {31'b0, mem_lock}, 32'd0);
    check_eq("hold_valid_set", {31'b0, dut.hold_valid}, 32'd1);
    next_cyc();
    aux_trans = 2'b00; aux_wdata = 32'hA5A5A5A5; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_aux_ready", {31'b0, aux_ready}, 32'd0);
      check_eq("stall_cpu_ready", {31'b0, cpu_ready}, 32'd0);
      check_eq("stall_state", {30'b0, arb_state}, 32'd1);
      next_cyc();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("aux_dp_state", {30'b0, arb_state}, 32'd1);
    next_cyc();
    aux_req = 1'b0;
    push_exp(32'h100, 1'b1, 32'h12345678, 1'b0);
    push_exp(32'h24, 1'b0, init_val(9), 1'b0);
    @(negedge clk);
    check_eq("exit_gnt", {31'b0, aux_gnt}, 32'd1);
    next_cyc();
    @(negedge clk);
    check_eq("replay_state", {30'b0, arb_state}, 32'd2);
    check_eq("replay_gnt", {31'b0, aux_gnt}, 32'd0);
    check_eq("replay_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check_eq("replay_addr", mem_addr, 32'h100);
    next_cyc();
    @(negedge clk);
    check_eq("back_state", {30'b0, arb_state}, 32'd0);
    next_cyc();
    cpu_trans = 2'b00;
    @(negedge clk);
    check_eq("mem_0x100", mem[64], 32'h12345678);
    check_eq("mem_0x200", mem[128], 32'hA5A5A5A5);
    next_cyc();

    // locked rmw holds off AUX, then switch with the CPU idle (no replay)
    aux_req = 1'b1; cpu_lock = 1'b1; cpu_trans = 2'b10; cpu_addr = 32'h40; cpu_write = 1'b0;
    push_exp(32'h40, 1'b0, init_val(16), 1'b0);
    @(negedge clk);
    check_eq("lock_gnt_rd", {31'b0, aux_gnt}, 32'd0);
    check_eq("lock_trans_rd", {30'b0, mem_trans}, 32'd2);
    check_eq("lock_mem_lock", {31'b0, mem_lock}, 32'd1);
    next_cyc();
    cpu_write = 1'b1;
    push_exp(32'h40, 1'b1, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    check_eq("lock_gnt_wr", {31'b0, aux_gnt}, 32'd0);
    check_eq("lock_state_wr", {30'b0, arb_state}, 32'd0);
    next_cyc();
    cpu_lock = 1'b0; cpu_trans = 2'b00; cpu_write = 1'b0; cpu_wdata = 32'h0BADF00D;
    @(negedge clk);
    check_eq("unlock_trans", {30'b0, mem_trans}, 32'd0);
    next_cyc();
    aux_trans = 2'b10; aux_addr = 32'h80; aux_write = 1'b0;
    push_exp(32'h80, 1'b0, init_val(32), 1'b1);
    @(negedge clk);
    check_eq("unlock_state", {30'b0, arb_state}, 32'd1);
    check_eq("unlock_gnt", {31'b0, aux_gnt}, 32'd1);
    check_eq("idle_no_hold", {31'b0, dut.hold_valid}, 32'd0);
    next_cyc();
    aux_trans = 2'b00;
    next_cyc();
    aux_req = 1'b0;
    next_cyc();
    @(negedge clk);
    check_eq("skip_replay_state", {30'b0, arb_state}, 32'd0);
    check_eq("skip_replay_gnt", {31'b0, aux_gnt}, 32'd0);
    check_eq("mem_0x40", mem[16], 32'h0BADF00D);
    next_cyc();

    // reset in the middle of a replay
    cpu_trans = 2'b10; cpu_addr = 32'h300; cpu_write = 1'b1; aux_req = 1'b1;
    @(negedge clk);
    check_eq("sw2_mem_trans", {30'b0, mem_trans}, 32'd0);
    next_cyc();
    cpu_trans = 2'b00; cpu_write = 1'b0; aux_req = 1'b0;
    @(negedge clk);
    check_eq("sw2_state", {30'b0, arb_state}, 32'd1);
    next_cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("replay2_state", {30'b0, arb_state}, 32'd2);
    check_eq("replay2_addr", mem_addr, 32'h300);
    #2 rst = 1'b1;
    #1;
    check_eq("rstrp_state", {30'b0, arb_state}, 32'd0);
    check_eq("rstrp_gnt", {31'b0, aux_gnt}, 32'd0);
    check_eq("rstrp_hold_valid", {31'b0, dut.hold_valid}, 32'd0);
    next_cyc();
    rst = 1'b0; mem_ready = 1'b1;
    next_cyc();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    check_eq("dp_drained", {31'b0, dp_pend}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/yrv_mem_arbiter.md
Name: yrv_mem_arbiter

Overview:
- Shares the single yrv_mcu memory port between the YRV core (CPU) and an auxiliary bus master (AUX), e.g. the aux-UART program loader.
- Sits between the core bus and the mcu memory/IO decode.
- The CPU has no grant input, so the block preempts it at a transfer boundary using a one-entry address-phase hold buffer and replays the held transfer after AUX finishes.
- The bus is pipelined (address phase, then data phase); a single ready signal completes the data phase and accepts the next address phase.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous active-high reset
- cpu_trans  in  2  CPU transfer type; 0 = idle
- cpu_addr  in  AW  CPU address
- cpu_write  in  1  CPU write enable
- cpu_ble  in  4  CPU byte lane enables
- cpu_lock  in  1  CPU lock (rmw)
- cpu_wdata  in  DW  CPU write data (data phase)
- cpu_ready  out  1  ready to CPU
- cpu_rdata  out  DW  read data to CPU
- aux_req  in  1  AUX bus request, level
- aux_gnt  out  1  AUX grant
- aux_trans, aux_addr, aux_write, aux_ble, aux_wdata  in  2/AW/1/4/DW  AUX bus, same meaning as the cpu_* inputs
- aux_ready  out  1  ready to AUX
- aux_rdata  out  DW  read data to AUX
- mem_trans, mem_addr, mem_write, mem_ble, mem_lock, mem_wdata  out  2/AW/1/4/1/DW  to memory
- mem_ready  in  1  memory ready
- mem_rdata  in  DW  memory read data
- arb_state  out  2  current state (debug)

Behaviour:
- States:
  - CPU: reset state; CPU drives mem_*.
  - SWITCH: combinational qualifier within CPU, not a separate state.
  - AUX: AUX drives mem_*.
  - REPLAY: the hold register drives mem_*.
- Reset: state=CPU, hold_valid=0, dphase_owner=CPU, aux_gnt=0, arb_state=0.
- Outputs after reset: mem_trans follows cpu_trans combinationally; cpu_ready=mem_ready; aux_ready=0.
- CPU state, sw = aux_req & ~cpu_lock:
  - sw=0: mem_* = cpu_*; cpu_ready = mem_ready.
  - sw=1: mem_trans forced to 0; cpu_ready = mem_ready.
  - sw=1 with mem_ready=1 at the edge:
    - If cpu_trans≠0, capture {trans, addr, write, ble} into the hold register; hold_valid=1.
    - Next state = AUX.
  - A locked sequence is never split: while cpu_lock=1 the CPU keeps ownership.
- AUX state:
  - aux_gnt=1; mem_* = aux_*; mem_lock=0; aux_ready = mem_ready; cpu_ready=0.
  - AUX may issue back-to-back transfers.
  - AUX drops aux_req only after its last data-phase ready.
  - Exit edge when aux_req=0 & aux_trans=0 & mem_ready=1: next state = REPLAY if hold_valid, else CPU.
  - aux_gnt deasserts the cycle after the exit edge.
- REPLAY state:
  - mem_* = hold register; mem_lock=0; cpu_ready=0.
  - On mem_ready=1: clear hold_valid; next state = CPU.
  - The held transfer's data phase then completes under normal CPU routing.
  - The CPU held cpu_wdata stable throughout, since its ready stayed low.
- Data phase routing:
  - dphase_owner register updates on every edge with mem_ready=1: CPU if the accepted address came from the CPU or the hold register, AUX if it came from AUX.
  - mem_wdata = owner's wdata.
  - cpu_rdata = aux_rdata = mem_rdata, unqualified; ready gating selects the consumer.
- Invariants:
  - At most one outstanding data phase.
  - Never both cpu_ready and aux_ready high in the same cycle.
- arb_state encoding: 0=CPU, 1=AUX, 2=REPLAY.
- aux_req asserted in REPLAY is not serviced until the state returns to CPU.
- reset mid-AUX or mid-REPLAY: immediate return to CPU; held transfer discarded.

Decomposition:
- Package yrv_arb_pkg: state enum arb_state_t {ST_CPU, ST_AUX, ST_REPLAY}; TRANS_IDLE=2'b00; owner_t enum.
- One sub-module, yrv_arb_hold: one-entry address-phase register with capture/clear and a valid flag.

Test Plan:
- CPU only, aux_req=0: 8 back-to-back reads at 0x0..0x1C, mem_ready always 1 -> mem_* equals cpu_* each cycle; cpu_ready=1; aux_gnt stays 0.
- aux_req rises while CPU issues a write to 0x100 -> in that cycle mem_trans=0 and cpu_ready=1; hold captures addr 0x100. Then aux_gnt=1; AUX writes 0xA5A5A5A5 to 0x200 completes; REPLAY drives 0x100; the CPU write data 0x12345678 lands at 0x100; cpu_ready low until then.
- cpu_lock=1 across a 2-transfer rmw with aux_req=1 -> no grant until lock drops; then switch within 1 cycle.
- mem_ready low for 3 cycles during AUX data phase -> aux_ready low 3 cycles; cpu_ready stays 0; state stays AUX.
- aux_req while CPU is idle (cpu_trans=0) -> hold_valid stays 0; AUX→CPU directly, skipping REPLAY.
- reset asserted in REPLAY -> same cycle: arb_state=0, aux_gnt=0, hold_valid=0.
